// File: rtl/syncfifo_shared_n.sv
// Shared-storage multi-queue FIFO: DEPTH payload slots are shared by NDEST
// destination queues, and each queue keeps its own FIFO of slot pointers.
module syncfifo_shared_n #(
    parameter int unsigned WID   = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NDEST = 4,
    parameter int unsigned QUOTA = DEPTH,
    localparam int unsigned AWID = $clog2(DEPTH),
    localparam int unsigned DWID = $clog2(NDEST)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        softreset,
    input  logic                        vldin,
    input  logic [WID-1:0]              din,
    input  logic [DWID-1:0]             destination,
    output logic                        accept,
    input  logic [NDEST-1:0]            readout,
    output logic [NDEST*WID-1:0]        dout,
    output logic [NDEST-1:0]            empty,
    output logic                        full,
    output logic [AWID:0]               count,
    output logic [NDEST*(AWID+1)-1:0]   dest_count,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam int unsigned CW = AWID + 1;

    logic [WID-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_occ;
    logic [AWID-1:0]  r_ptr [NDEST][DEPTH];
    logic [CW-1:0]    r_rd [NDEST];
    logic [CW-1:0]    r_wr [NDEST];
    logic [CW-1:0]    r_dcnt [NDEST];
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic [NDEST-1:0] w_empty;
    logic [NDEST-1:0] w_pop;
    logic [NDEST-1:0] w_push;
    logic [AWID-1:0]  w_head [NDEST];
    logic [CW-1:0]    w_dcnt_sel;
    logic             w_dest_ok;
    logic             w_quota_ok;
    logic             w_full;
    logic             w_accept;
    logic [AWID-1:0]  w_free;
    logic [DEPTH-1:0] w_occ_nxt;
    logic [CW-1:0]    w_count_nxt;

    // Per-queue head pointer, empty flag and qualified pop
    always_comb begin
        for (int i = 0; i < NDEST; i++) begin
            w_empty[i] = (r_rd[i] == r_wr[i]);
            w_head[i]  = r_ptr[i][r_rd[i][AWID-1:0]];
            w_pop[i]   = readout[i] && !w_empty[i] && !softreset;
        end
    end

    always_comb begin
        w_dcnt_sel = '0;
        for (int i = 0; i < NDEST; i++) begin
            if (destination == DWID'(i)) w_dcnt_sel = r_dcnt[i];
        end
    end

    assign w_dest_ok  = (32'(destination) < NDEST);
    assign w_quota_ok = (32'(w_dcnt_sel) < QUOTA);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_accept   = vldin && !w_full && w_dest_ok && w_quota_ok && !softreset;

    // Lowest-index free slot from pre-edge occupancy; slots freed this cycle are not eligible
    always_comb begin
        w_free = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (!r_occ[s]) w_free = AWID'(s);
        end
    end

    always_comb begin
        for (int i = 0; i < NDEST; i++) begin
            w_push[i] = w_accept && (destination == DWID'(i));
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        for (int i = 0; i < NDEST; i++) begin
            if (w_pop[i]) w_occ_nxt[w_head[i]] = 1'b0;
        end
        if (w_accept) w_occ_nxt[w_free] = 1'b1;
        w_count_nxt = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_count_nxt = w_count_nxt + CW'(w_occ_nxt[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NDEST; i++) begin
                r_rd[i]   <= '0;
                r_wr[i]   <= '0;
                r_dcnt[i] <= '0;
                for (int s = 0; s < DEPTH; s++) r_ptr[i][s] <= '0;
            end
        end else if (softreset) begin
            r_occ      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NDEST; i++) begin
                r_rd[i]   <= '0;
                r_wr[i]   <= '0;
                r_dcnt[i] <= '0;
                for (int s = 0; s < DEPTH; s++) r_ptr[i][s] <= '0;
            end
        end else begin
            r_occ   <= w_occ_nxt;
            r_count <= w_count_nxt;
            if (clr_overflow) begin
                r_overflow <= 1'b0;
            end else if (vldin && !w_accept) begin
                r_overflow <= 1'b1;
            end
            for (int i = 0; i < NDEST; i++) begin
                if (w_push[i]) begin
                    r_ptr[i][r_wr[i][AWID-1:0]] <= w_free;
                    r_wr[i] <= r_wr[i] + CW'(1);
                end
                if (w_pop[i]) r_rd[i] <= r_rd[i] + CW'(1);
                if (w_push[i] && !w_pop[i]) begin
                    r_dcnt[i] <= r_dcnt[i] + CW'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_dcnt[i] <= r_dcnt[i] - CW'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; dout masks it while a queue is empty
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[w_free] <= din;
    end

    always_comb begin
        dout       = '0;
        dest_count = '0;
        for (int i = 0; i < NDEST; i++) begin
            if (!w_empty[i]) dout[i*WID +: WID] = r_mem[w_head[i]];
            dest_count[i*CW +: CW] = r_dcnt[i];
        end
    end

    assign accept   = w_accept;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_syncfifo_shared_n.sv
// Bench for syncfifo_shared_n: directed scenarios plus random traffic checked
// against a queue-of-values reference model.
module tb_syncfifo_shared_n;

    localparam int unsigned WID   = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NDEST = 4;
    localparam int unsigned CW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic                    softreset, vldin, accept, full, overflow, clr_overflow;
    logic [WID-1:0]          din;
    logic [1:0]              destination;
    logic [NDEST-1:0]        readout, empty;
    logic [NDEST*WID-1:0]    dout;
    logic [CW-1:0]           count;
    logic [NDEST*CW-1:0]     dest_count;

    syncfifo_shared_n u_dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset), .vldin(vldin), .din(din),
        .destination(destination), .accept(accept), .readout(readout), .dout(dout),
        .empty(empty), .full(full), .count(count), .dest_count(dest_count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    // QUOTA=3 instance
    logic        q_sr, q_vldin, q_accept, q_full, q_overflow, q_clr;
    logic [7:0]  q_din;
    logic [1:0]  q_dest;
    logic [3:0]  q_readout, q_empty;
    logic [31:0] q_dout;
    logic [4:0]  q_count;
    logic [19:0] q_dest_count;

    syncfifo_shared_n #(.WID(8), .DEPTH(16), .NDEST(4), .QUOTA(3)) u_quota (
        .clk(clk), .rst_n(rst_n), .softreset(q_sr), .vldin(q_vldin), .din(q_din),
        .destination(q_dest), .accept(q_accept), .readout(q_readout), .dout(q_dout),
        .empty(q_empty), .full(q_full), .count(q_count), .dest_count(q_dest_count),
        .overflow(q_overflow), .clr_overflow(q_clr)
    );

    // NDEST=3 instance
    logic        b_sr, b_vldin, b_accept, b_full, b_overflow, b_clr;
    logic [7:0]  b_din;
    logic [1:0]  b_dest;
    logic [2:0]  b_readout, b_empty;
    logic [23:0] b_dout;
    logic [4:0]  b_count;
    logic [14:0] b_dest_count;

    syncfifo_shared_n #(.WID(8), .DEPTH(16), .NDEST(3)) u_bad (
        .clk(clk), .rst_n(rst_n), .softreset(b_sr), .vldin(b_vldin), .din(b_din),
        .destination(b_dest), .accept(b_accept), .readout(b_readout), .dout(b_dout),
        .empty(b_empty), .full(b_full), .count(b_count), .dest_count(b_dest_count),
        .overflow(b_overflow), .clr_overflow(b_clr)
    );

    // Reference model: one queue of payload values per destination
    logic [WID-1:0] mq [NDEST][$];
    bit             m_ovf;
    int             n_tests = 0;
    int             n_fail = 0;
    bit             exp_acc, got_acc;

    function automatic int m_total();
        int t = 0;
        for (int i = 0; i < NDEST; i++) t += mq[i].size();
        return t;
    endfunction

    function automatic logic [NDEST*WID-1:0] m_dout();
        logic [NDEST*WID-1:0] r = '0;
        for (int i = 0; i < NDEST; i++) if (mq[i].size() > 0) r[i*WID +: WID] = mq[i][0];
        return r;
    endfunction

    function automatic logic [NDEST-1:0] m_empty();
        logic [NDEST-1:0] r = '0;
        for (int i = 0; i < NDEST; i++) r[i] = (mq[i].size() == 0);
        return r;
    endfunction

    function automatic logic [NDEST*CW-1:0] m_dcnt();
        logic [NDEST*CW-1:0] r = '0;
        for (int i = 0; i < NDEST; i++) r[i*CW +: CW] = CW'(mq[i].size());
        return r;
    endfunction

    // One clock of stimulus on the default instance; model advances in step
    task automatic tick(input bit v, input logic [WID-1:0] d_in, input logic [1:0] d,
                        input logic [3:0] rd, input bit clr, input bit sr);
        vldin = v; din = d_in; destination = d; readout = rd;
        clr_overflow = clr; softreset = sr;
        #1;
        got_acc = accept;
        exp_acc = v && !sr && (m_total() < int'(DEPTH)) && (mq[d].size() < int'(DEPTH));
        if (sr) begin
            for (int i = 0; i < NDEST; i++) mq[i].delete();
            m_ovf = 1'b0;
        end else begin
            for (int i = 0; i < NDEST; i++) if (rd[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            if (exp_acc) mq[d].push_back(d_in);
            if (clr) m_ovf = 1'b0;
            else if (v && !exp_acc) m_ovf = 1'b1;
        end
        @(posedge clk); #1;
        vldin = 1'b0; readout = '0; clr_overflow = 1'b0; softreset = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++; if (empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty got=%h exp=f", empty); end
        n_tests++; if (full !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL reset_full_count full=%b count=%0d exp 0/0", full, count); end
        n_tests++; if (dest_count !== '0 || dout !== '0) begin n_fail++; $display("FAIL reset_dcnt_dout dcnt=%h dout=%h exp 0", dest_count, dout); end
        n_tests++; if (overflow !== 1'b0 || accept !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_acc ovf=%b acc=%b exp 0/0", overflow, accept); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, WID'(k), 2'(k % 4), 4'b0, 1'b0, 1'b0);
            n_tests++; if (got_acc !== 1'b1) begin n_fail++; $display("FAIL rr_accept k=%0d got=%b exp=1", k, got_acc); end
        end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL rr_full got=%b exp=1", full); end
        n_tests++; if (dest_count !== {4{5'd4}}) begin n_fail++; $display("FAIL rr_dcnt got=%h exp=%h", dest_count, {4{5'd4}}); end
        n_tests++; if (dout !== m_dout()) begin n_fail++; $display("FAIL rr_dout got=%h exp=%h", dout, m_dout()); end
        for (int j = 0; j < 4; j++) begin
            n_tests++; if (dout[31:0] !== 32'(j * 4)) begin n_fail++; $display("FAIL rr_pop_q0 j=%0d got=%0d exp=%0d", j, dout[31:0], j * 4); end
            tick(1'b0, '0, 2'd0, 4'b0001, 1'b0, 1'b0);
        end
        n_tests++; if (empty[0] !== 1'b1 || count !== 5'd12) begin n_fail++; $display("FAIL rr_drained empty0=%b count=%0d exp 1/12", empty[0], count); end
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 4; k++) tick(1'b1, $urandom, 2'd0, 4'b0, 1'b0, 1'b0);
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fp_full got=%b exp=1", full); end
        tick(1'b1, $urandom, 2'd1, 4'b0100, 1'b0, 1'b0);
        n_tests++; if (got_acc !== 1'b0) begin n_fail++; $display("FAIL fp_accept got=%b exp=0", got_acc); end
        n_tests++; if (overflow !== 1'b1 || count !== 5'd15) begin n_fail++; $display("FAIL fp_after ovf=%b count=%0d exp 1/15", overflow, count); end
        tick(1'b1, $urandom, 2'd1, 4'b0, 1'b0, 1'b0);
        n_tests++; if (got_acc !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fp_refill acc=%b count=%0d exp 1/16", got_acc, count); end
        tick(1'b1, $urandom, 2'd0, 4'b0, 1'b1, 1'b0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_clr_wins got=%b exp=0", overflow); end
    endtask

    task automatic test_parallel_pop();
        logic [4:0]  c0;
        logic [19:0] d0;
        tick(1'b0, '0, 2'd0, 4'b1000, 1'b0, 1'b0);
        c0 = count; d0 = dest_count;
        n_tests++; if (c0 !== 5'd15 || empty !== 4'b0000) begin n_fail++; $display("FAIL pp_pre count=%0d empty=%b exp 15/0000", c0, empty); end
        tick(1'b1, $urandom, 2'd0, 4'b1111, 1'b0, 1'b0);
        n_tests++; if (got_acc !== 1'b1 || count !== c0 - 5'd3) begin n_fail++; $display("FAIL pp_count acc=%b count=%0d exp 1/%0d", got_acc, count, c0 - 5'd3); end
        n_tests++; if (dest_count[4:0] !== d0[4:0]) begin n_fail++; $display("FAIL pp_q0 got=%0d exp=%0d", dest_count[4:0], d0[4:0]); end
        for (int i = 1; i < 4; i++) begin
            n_tests++; if (dest_count[i*5 +: 5] !== d0[i*5 +: 5] - 5'd1) begin n_fail++; $display("FAIL pp_q%0d got=%0d exp=%0d", i, dest_count[i*5 +: 5], d0[i*5 +: 5] - 5'd1); end
        end
        n_tests++; if (dout !== m_dout()) begin n_fail++; $display("FAIL pp_dout got=%h exp=%h", dout, m_dout()); end
    endtask

    task automatic test_softreset();
        tick(1'b0, '0, 2'd0, 4'b0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) tick(1'b1, $urandom, 2'(k % 4), 4'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 2'd0, 4'b1111, 1'b0, 1'b0);
        tick(1'b0, '0, 2'd0, 4'b0011, 1'b0, 1'b0);
        n_tests++; if (count !== 5'd10 || overflow !== 1'b1) begin n_fail++; $display("FAIL sr_pre count=%0d ovf=%b exp 10/1", count, overflow); end
        tick(1'b1, $urandom, 2'd2, 4'b1111, 1'b0, 1'b1);
        n_tests++; if (got_acc !== 1'b0) begin n_fail++; $display("FAIL sr_accept got=%b exp=0", got_acc); end
        n_tests++; if (count !== 5'd0 || empty !== 4'hF || overflow !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL sr_state count=%0d empty=%b ovf=%b dout=%h exp 0/1111/0/0", count, empty, overflow, dout); end
        tick(1'b1, 32'hA5A5_0001, 2'd2, 4'b0, 1'b0, 1'b0);
        n_tests++; if (got_acc !== 1'b1 || dout[64 +: 32] !== 32'hA5A5_0001 || dest_count[10 +: 5] !== 5'd1) begin n_fail++; $display("FAIL sr_push acc=%b dout2=%h dcnt2=%0d exp 1/a5a50001/1", got_acc, dout[64 +: 32], dest_count[10 +: 5]); end
    endtask

    task automatic test_random();
        logic [3:0] rd;
        for (int c = 0; c < 400; c++) begin
            rd = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            tick($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)), rd,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            n_tests++; if (got_acc !== exp_acc) begin n_fail++; $display("FAIL rnd_accept c=%0d got=%b exp=%b", c, got_acc, exp_acc); end
            n_tests++; if (dout !== m_dout()) begin n_fail++; $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, dout, m_dout()); end
            n_tests++; if (empty !== m_empty()) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, empty, m_empty()); end
            n_tests++; if (count !== CW'(m_total()) || full !== (m_total() == int'(DEPTH))) begin n_fail++; $display("FAIL rnd_count c=%0d count=%0d full=%b exp=%0d", c, count, full, m_total()); end
            n_tests++; if (dest_count !== m_dcnt()) begin n_fail++; $display("FAIL rnd_dcnt c=%0d got=%h exp=%h", c, dest_count, m_dcnt()); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
        end
    endtask

    task automatic test_quota();
        for (int k = 0; k < 4; k++) begin
            q_vldin = 1'b1; q_din = 8'(k); q_dest = 2'd1;
            #1;
            n_tests++; if (q_accept !== (k < 3)) begin n_fail++; $display("FAIL quota_accept k=%0d got=%b exp=%b", k, q_accept, k < 3); end
            @(posedge clk); #1;
        end
        q_vldin = 1'b0;
        n_tests++; if (q_dest_count[5 +: 5] !== 5'd3 || q_overflow !== 1'b1) begin n_fail++; $display("FAIL quota_state dcnt1=%0d ovf=%b exp 3/1", q_dest_count[5 +: 5], q_overflow); end
        q_clr = 1'b1;
        @(posedge clk); #1;
        q_clr = 1'b0;
        n_tests++; if (q_overflow !== 1'b0) begin n_fail++; $display("FAIL quota_clr got=%b exp=0", q_overflow); end
    endtask

    task automatic test_bad_dest();
        b_vldin = 1'b1; b_din = 8'h3C; b_dest = 2'd3;
        #1;
        n_tests++; if (b_accept !== 1'b0) begin n_fail++; $display("FAIL bad_accept got=%b exp=0", b_accept); end
        @(posedge clk); #1;
        b_vldin = 1'b0;
        n_tests++; if (b_overflow !== 1'b1 || b_count !== 5'd0 || b_empty !== 3'b111) begin n_fail++; $display("FAIL bad_state ovf=%b count=%0d empty=%b exp 1/0/111", b_overflow, b_count, b_empty); end
        b_vldin = 1'b1; b_dest = 2'd2;
        #1;
        n_tests++; if (b_accept !== 1'b1) begin n_fail++; $display("FAIL bad_last_dest got=%b exp=1", b_accept); end
        @(posedge clk); #1;
        b_vldin = 1'b0;
        n_tests++; if (b_dout[16 +: 8] !== 8'h3C || b_empty !== 3'b011) begin n_fail++; $display("FAIL bad_last_state dout2=%h empty=%b exp 3c/011", b_dout[16 +: 8], b_empty); end
    endtask

    initial begin
        softreset = 1'b0; vldin = 1'b0; din = '0; destination = '0; readout = '0; clr_overflow = 1'b0;
        q_sr = 1'b0; q_vldin = 1'b0; q_din = '0; q_dest = '0; q_readout = '0; q_clr = 1'b0;
        b_sr = 1'b0; b_vldin = 1'b0; b_din = '0; b_dest = '0; b_readout = '0; b_clr = 1'b0;
        m_ovf = 1'b0;
        test_reset();
        test_round_robin();
        test_full_pop();
        test_parallel_pop();
        test_softreset();
        test_random();
        test_quota();
        test_bad_dest();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syncfifo_shared_n.md
SYNCFIFO_SHARED_N -- requirements
Module: syncfifo_shared_n

Interface
- REQ-001 SHALL provide parameter WID, default 32: payload width in bits.
- REQ-002 SHALL provide parameter DEPTH, default 16: number of shared storage slots, power of two, at least 2.
- REQ-003 SHALL provide parameter NDEST, default 4: number of destination queues, from 2 to 16.
- REQ-004 SHALL provide parameter QUOTA, default DEPTH: maximum entries one destination may hold, from 1 to DEPTH.
- REQ-005 SHALL define the following derived widths: AWID=clog2(DEPTH); DWID=clog2(NDEST).
- REQ-006 SHALL provide the following ports:
  - clk  in  1  clock, all logic on rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - softreset  in  1  synchronous clear.
  - vldin  in  1  push request.
  - din  in  WID  push payload.
  - destination  in  DWID  target queue of the push.
  - accept  out  1  push taken this cycle (combinational).
  - readout  in  NDEST  per-queue pop request.
  - dout  out  NDEST*WID  per-queue head; queue i occupies bits [i*WID +: WID].
  - empty  out  NDEST  per-queue empty flag.
  - full  out  1  all DEPTH slots occupied.
  - count  out  AWID+1  total occupied slots.
  - dest_count  out  NDEST*(AWID+1)  per-queue occupancy.
  - overflow  out  1  sticky rejected-push flag.
  - clr_overflow  in  1  clears overflow.

Function
- REQ-007 SHALL compute accept = vldin && !full && (destination < NDEST) && (dest_count[destination] < QUOTA) && !softreset.
- REQ-008 SHALL, on accept, write din into the lowest-index unoccupied slot and append that slot index to queue destination's pointer FIFO (NDEST pointer FIFOs, each DEPTH deep, AWID wide).
- REQ-009 SHALL pop queue i exactly when readout[i] && !empty[i] && !softreset: the head slot is freed and the queue pointer advances. readout[i] while empty[i] is ignored.
- REQ-010 SHALL drive dout[i] combinationally from the head slot of queue i; dout[i] SHALL be all-zero while empty[i]=1.
- REQ-011 SHALL give push-to-visible latency of 1 cycle: empty deasserts, and count and dest_count update, on the edge after accept.
- REQ-012 SHALL allow any subset of queues to pop in the same cycle as one push; all pops and the push SHALL take effect on the same edge.
- REQ-013 SHALL NOT reuse a slot freed in cycle N for a push in cycle N: free-slot selection uses pre-edge occupancy. Consequently a push while full=1 is rejected even if a pop occurs in the same cycle.
- REQ-014 SHALL register count as the popcount of occupancy; count SHALL equal the sum of all dest_count values at every cycle.
- REQ-015 SHALL assert full exactly when count == DEPTH.
- REQ-016 SHALL update per-queue dest_count as +1 on push, -1 on pop, unchanged on simultaneous push and pop to the same queue.
- REQ-017 SHALL set overflow on the edge after vldin=1 with accept=0 (causes: full, quota reached, or destination >= NDEST).
- REQ-018 SHALL hold overflow until clr_overflow or reset; clr_overflow SHALL win over a simultaneous set.
- REQ-019 SHALL preserve per-queue FIFO order; there SHALL be no ordering relation between queues.
- REQ-020 SHALL keep pointer wrap-around internal, with each pointer FIFO using AWID+1-bit read/write indices. A pointer FIFO SHALL never overflow, since a queue holds at most QUOTA <= DEPTH entries.

Reset
- REQ-021 SHALL, on rst_n low, asynchronously clear occupancy, all pointer FIFOs, and overflow, giving: empty all ones, full 0, count 0, dest_count 0, dout 0, accept 0.
- REQ-022 SHALL, on softreset=1 at an edge, produce the same state as REQ-021 on that edge, overriding any push, pop, or overflow set in that cycle.
- REQ-023 SHALL leave slot storage contents unreset; it is never observable, because dout is masked while empty.

Verification
- REQ-024 SHALL cover round-robin fill: after reset, 16 pushes din=k, destination=k%4 (defaults) -> full=1, each dest_count=4, dout[0]=0 after the last push; pops return 0,4,8,12 on queue 0.
- REQ-025 SHALL cover full with simultaneous pop: full=1, vldin=1 and readout[2]=1 in the same cycle -> accept=0, overflow=1 next cycle, count=15; next-cycle push -> accept=1, count=16.
- REQ-026 SHALL cover quota: QUOTA=3, 4 pushes to destination 1 -> 4th accept=0, dest_count[1]=3, overflow=1; clr_overflow pulse -> overflow=0.
- REQ-027 SHALL cover a parallel pop across all queues: all 4 queues non-empty, readout=4'b1111 with a push to queue 0 -> count drops by 3, dest_count[0] unchanged, the other queues each drop by 1.
- REQ-028 SHALL cover invalid destination: NDEST=3, destination=3 -> accept=0, overflow=1, state unchanged.
- REQ-029 SHALL cover softreset mid-traffic: 10 entries held, softreset=1 with vldin and readout active -> next cycle count=0, empty all ones, overflow=0; a subsequent push lands in slot 0.
